// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator for the MEM stage.
// One load/store per op over a req/gnt/rvalid word bus, with lane steering,
// load extension, stall generation and fault reporting.
// Optional build macro: LSU_MISALIGNED_SPLIT_EN -- misaligned H/W accesses are
// split into two word transactions instead of raising misalignedFault.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsuValid,
  input  logic        lsuLoad,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        lsuBusy,
  output logic        lsuDone,
  output logic [31:0] loadResult,
  output logic        misalignedFault,
  output logic        busFault,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memByteEn,
  output logic [31:0] memWData,
  input  logic        memGnt,
  input  logic        memRValid,
  input  logic [31:0] memRData
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam int unsigned BEW = 8;
  localparam int unsigned WDW = 64;
`else
  localparam int unsigned BEW = 4;
  localparam int unsigned WDW = 32;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT
`ifdef LSU_MISALIGNED_SPLIT_EN
    , S_REQ2
`endif
  } state_t;

  state_t r_state;
  state_t w_next;

  // Captured op
  logic           r_load;
  logic [2:0]     r_func3;
  logic [1:0]     r_off;
  logic [31:0]    r_addrWord;
  logic [BEW-1:0] r_be;
  logic [WDW-1:0] r_wdata;
  logic [7:0]     r_cnt;
  logic [31:0]    r_loadResult;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic           r_split;
  logic           r_second;
  logic [31:0]    r_rdata1;
`else
  logic           r_misal;
`endif

  // Decode of the incoming op
  logic           w_legal;
  logic           w_misal;
  logic [3:0]     w_mask;
  logic [BEW-1:0] w_be;
  logic [31:0]    w_wrep;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [63:0]    w_wshift;
`endif
  logic           w_tmo;
  logic [31:0]    w_rword;
  logic [31:0]    w_ext;

  assign w_tmo = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Decode legality, alignment, lane mask and store-lane replication
  always_comb begin
    w_legal = 1'b0;
    w_misal = 1'b0;
    w_mask  = 4'b1111;
    w_wrep  = storeData;
    if (lsuLoad) w_legal = (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else         w_legal = (func3 inside {3'b000, 3'b001, 3'b010});
    unique case (func3[1:0])
      2'b00: begin
        w_mask = 4'b0001;
        w_wrep = {4{storeData[7:0]}};
      end
      2'b01: begin
        w_mask  = 4'b0011;
        w_wrep  = {2{storeData[15:0]}};
        w_misal = address[0];
      end
      default: begin
        w_mask  = 4'b1111;
        w_wrep  = storeData;
        w_misal = (address[1:0] != 2'b00);
      end
    endcase
    w_be = BEW'(w_mask) << address[1:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
    w_wshift = {32'b0, storeData} << {address[1:0], 3'b000};
`endif
  end

  // Shift the response so the addressed byte lands in lane 0, then extend
  always_comb begin
`ifdef LSU_MISALIGNED_SPLIT_EN
    w_rword = 32'((r_second ? {memRData, r_rdata1} : {32'b0, memRData}) >> {r_off, 3'b000});
`else
    w_rword = memRData >> {r_off, 3'b000};
`endif
    unique case (r_func3)
      3'b000:  w_ext = {{24{w_rword[7]}}, w_rword[7:0]};
      3'b001:  w_ext = {{16{w_rword[15]}}, w_rword[15:0]};
      3'b100:  w_ext = {24'b0, w_rword[7:0]};
      3'b101:  w_ext = {16'b0, w_rword[15:0]};
      default: w_ext = w_rword;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a handshake in the final timeout cycle wins over the timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (lsuValid) begin
          if (!w_legal) w_next = S_FAULT;
`ifdef LSU_MISALIGNED_SPLIT_EN
          else          w_next = S_REQ;
`else
          else if (w_misal) w_next = S_FAULT;
          else              w_next = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (memGnt)     w_next = S_WAIT;
        else if (w_tmo) w_next = S_FAULT;
      end
      S_WAIT: begin
        if (memRValid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (r_split && !r_second) w_next = S_REQ2;
          else                      w_next = S_DONE;
`else
          w_next = S_DONE;
`endif
        end else if (w_tmo) w_next = S_FAULT;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ2: begin
        if (memGnt)     w_next = S_WAIT;
        else if (w_tmo) w_next = S_FAULT;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Op capture, timeout counter, first-half data and load result
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_load       <= 1'b0;
      r_func3      <= '0;
      r_off        <= '0;
      r_addrWord   <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_loadResult <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_split      <= 1'b0;
      r_second     <= 1'b0;
      r_rdata1     <= '0;
`else
      r_misal      <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && lsuValid) begin
        r_load     <= lsuLoad;
        r_func3    <= func3;
        r_off      <= address[1:0];
        r_addrWord <= {address[31:2], 2'b00};
        r_be       <= w_be;
`ifdef LSU_MISALIGNED_SPLIT_EN
        r_split    <= w_misal;
        r_second   <= 1'b0;
        r_wdata    <= w_misal ? w_wshift : {32'b0, w_wrep};
`else
        r_misal    <= w_legal && w_misal;
        r_wdata    <= w_wrep;
`endif
      end
      // Counter restarts at each transaction; it only advances in REQ/WAIT(/REQ2)
      if (r_state == S_IDLE || (r_state == S_WAIT && memRValid)) r_cnt <= '0;
      else if (r_state != S_DONE && r_state != S_FAULT)         r_cnt <= r_cnt + 8'd1;
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (r_state == S_WAIT && memRValid && r_split && !r_second) begin
        r_rdata1 <= memRData;
        r_second <= 1'b1;
      end
`endif
      if (r_state == S_WAIT && memRValid && w_next == S_DONE && r_load)
        r_loadResult <= w_ext;
    end
  end

  // Bus and status outputs decoded from state; everything idles at zero
  always_comb begin
    lsuBusy         = (r_state != S_IDLE);
    lsuDone         = (r_state == S_DONE);
    loadResult      = r_loadResult;
    busFault        = 1'b0;
    misalignedFault = 1'b0;
    memReq          = 1'b0;
    memWe           = 1'b0;
    memAddr         = '0;
    memByteEn       = '0;
    memWData        = '0;
    unique case (r_state)
      S_REQ: begin
        memReq    = 1'b1;
        memWe     = !r_load;
        memAddr   = r_addrWord;
        memByteEn = r_be[3:0];
        memWData  = r_load ? '0 : r_wdata[31:0];
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ2: begin
        memReq    = 1'b1;
        memWe     = !r_load;
        memAddr   = r_addrWord + 32'd4;
        memByteEn = r_be[7:4];
        memWData  = r_load ? '0 : r_wdata[63:32];
      end
      S_FAULT: busFault = 1'b1;
`else
      S_FAULT: begin
        misalignedFault = r_misal;
        busFault        = !r_misal;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=8).
module tb_load_store_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lsuValid = 1'b0, lsuLoad = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] address = '0, storeData = '0;
  logic        lsuBusy, lsuDone, misalignedFault, busFault;
  logic [31:0] loadResult;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWData;
  logic [3:0]  memByteEn;
  logic        memGnt = 1'b0, memRValid = 1'b0;
  logic [31:0] memRData = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .lsuValid(lsuValid), .lsuLoad(lsuLoad),
    .func3(func3), .address(address), .storeData(storeData),
    .lsuBusy(lsuBusy), .lsuDone(lsuDone), .loadResult(loadResult),
    .misalignedFault(misalignedFault), .busFault(busFault),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memByteEn(memByteEn),
    .memWData(memWData), .memGnt(memGnt), .memRValid(memRValid), .memRData(memRData)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock); #1;
  endtask

  // One aligned op: grant after gdly extra REQ cycles, response one cycle after grant
  task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] a, sd, rd,
                        input int unsigned gdly, output logic stable, output logic [31:0] oaddr,
                        output logic [3:0] obe, output logic [31:0] owd, output logic owe,
                        output logic odone, output logic [31:0] ores);
    lsuValid = 1'b1; lsuLoad = ld; func3 = f3; address = a; storeData = sd;
    step();
    lsuValid = 1'b0;
    oaddr = memAddr; obe = memByteEn; owd = memWData; owe = memWe;
    stable = memReq && lsuBusy;
    for (int i = 0; i < int'(gdly); i++) begin
      step();
      if (!(memReq && lsuBusy && memAddr == oaddr && memByteEn == obe && memWData == owd))
        stable = 1'b0;
    end
    memGnt = 1'b1;
    step();
    memGnt = 1'b0;
    if (memReq || !lsuBusy) stable = 1'b0;
    memRValid = 1'b1; memRData = rd;
    step();
    memRValid = 1'b0;
    odone = lsuDone; ores = loadResult;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    n_vec++;
    if ({lsuBusy, lsuDone, misalignedFault, busFault, memReq, memWe} !== 6'b0 ||
        memAddr !== 32'h0 || memByteEn !== 4'h0 || memWData !== 32'h0 || loadResult !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b mf=%b bf=%b req=%b we=%b addr=%h be=%b wd=%h res=%h, want all 0",
               lsuBusy, lsuDone, misalignedFault, busFault, memReq, memWe, memAddr, memByteEn, memWData, loadResult);
    end
  endtask

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [3:0]  be;
    logic [31:0] wd;
  } st_vec_t;

  task automatic test_stores();
    st_vec_t v[4];
    logic st; logic [31:0] oa, ow, orr, prev; logic [3:0] ob; logic owe, od;
    v[0] = '{3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5};
    v[1] = '{3'b001, 32'h102, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF};
    v[2] = '{3'b010, 32'h104, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
    v[3] = '{3'b000, 32'h100, 32'h1234567C, 4'b0001, 32'h7C7C7C7C};
    for (int i = 0; i < 4; i++) begin
      prev = loadResult;
      run_op(1'b0, v[i].f3, v[i].a, v[i].sd, 32'h0, 0, st, oa, ob, ow, owe, od, orr);
      n_vec++;
      if (oa !== {v[i].a[31:2], 2'b00} || ob !== v[i].be || ow !== v[i].wd || owe !== 1'b1) begin
        n_err++;
        $display("FAIL store_bus[%0d]: got addr=%h be=%b wd=%h we=%b, want addr=%h be=%b wd=%h we=1",
                 i, oa, ob, ow, owe, {v[i].a[31:2], 2'b00}, v[i].be, v[i].wd);
      end
      n_vec++;
      if (od !== 1'b1 || st !== 1'b1 || orr !== prev) begin
        n_err++;
        $display("FAIL store_done[%0d]: got done=%b reqok=%b res=%h, want done=1 reqok=1 res=%h", i, od, st, orr, prev);
      end
    end
  endtask

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] res;
  } ld_vec_t;

  task automatic test_loads();
    ld_vec_t v[7];
    logic st; logic [31:0] oa, ow, orr; logic [3:0] ob; logic owe, od;
    v[0] = '{3'b000, 32'h102, 32'h12803456, 4'b0100, 32'hFFFFFF80};
    v[1] = '{3'b100, 32'h102, 32'h12803456, 4'b0100, 32'h00000080};
    v[2] = '{3'b010, 32'h100, 32'h12803456, 4'b1111, 32'h12803456};
    v[3] = '{3'b001, 32'h100, 32'h1234ABCD, 4'b0011, 32'hFFFFABCD};
    v[4] = '{3'b101, 32'h100, 32'h1234ABCD, 4'b0011, 32'h0000ABCD};
    v[5] = '{3'b001, 32'h102, 32'h12803456, 4'b1100, 32'h00001280};
    v[6] = '{3'b000, 32'h101, 32'h12803456, 4'b0010, 32'h00000034};
    for (int i = 0; i < 7; i++) begin
      run_op(1'b1, v[i].f3, v[i].a, 32'hFFFFFFFF, v[i].rd, 0, st, oa, ob, ow, owe, od, orr);
      n_vec++;
      if (oa !== {v[i].a[31:2], 2'b00} || ob !== v[i].be || owe !== 1'b0 || st !== 1'b1) begin
        n_err++;
        $display("FAIL load_bus[%0d]: got addr=%h be=%b we=%b reqok=%b, want addr=%h be=%b we=0 reqok=1",
                 i, oa, ob, owe, st, {v[i].a[31:2], 2'b00}, v[i].be);
      end
      n_vec++;
      if (od !== 1'b1 || orr !== v[i].res) begin
        n_err++;
        $display("FAIL load_result[%0d]: got done=%b res=%h, want done=1 res=%h", i, od, orr, v[i].res);
      end
    end
  endtask

`ifdef LSU_MISALIGNED_SPLIT_EN
  task automatic test_misaligned();
    logic [31:0] a1, a2; logic [3:0] b1, b2; logic r1, r2, d;
    lsuValid = 1'b1; lsuLoad = 1'b1; func3 = 3'b001; address = 32'h103;
    step();
    lsuValid = 1'b0;
    r1 = memReq; a1 = memAddr; b1 = memByteEn;
    memGnt = 1'b1; step(); memGnt = 1'b0;
    memRValid = 1'b1; memRData = 32'hAABBCCDD; step(); memRValid = 1'b0;
    r2 = memReq; a2 = memAddr; b2 = memByteEn;
    memGnt = 1'b1; step(); memGnt = 1'b0;
    memRValid = 1'b1; memRData = 32'h11223344; step(); memRValid = 1'b0;
    d = lsuDone;
    n_vec++;
    if (r1 !== 1'b1 || a1 !== 32'h100 || b1 !== 4'b1000 || r2 !== 1'b1 || a2 !== 32'h104 || b2 !== 4'b0001) begin
      n_err++;
      $display("FAIL split_bus: got %b/%h/%b then %b/%h/%b, want 1/00000100/1000 then 1/00000104/0001",
               r1, a1, b1, r2, a2, b2);
    end
    n_vec++;
    if (d !== 1'b1 || loadResult !== 32'h000044AA || misalignedFault !== 1'b0) begin
      n_err++;
      $display("FAIL split_result: got done=%b res=%h mf=%b, want done=1 res=000044aa mf=0", d, loadResult, misalignedFault);
    end
    step();
  endtask
`else
  task automatic test_misaligned();
    logic [2:0]  f3s[2];
    logic [31:0] as[2];
    f3s[0] = 3'b001; as[0] = 32'h103;
    f3s[1] = 3'b010; as[1] = 32'h102;
    for (int i = 0; i < 2; i++) begin
      lsuValid = 1'b1; lsuLoad = 1'b1; func3 = f3s[i]; address = as[i];
      step();
      lsuValid = 1'b0;
      n_vec++;
      if (misalignedFault !== 1'b1 || busFault !== 1'b0 || memReq !== 1'b0 || lsuDone !== 1'b0) begin
        n_err++;
        $display("FAIL misaligned_pulse[%0d]: got mf=%b bf=%b req=%b done=%b, want mf=1 bf=0 req=0 done=0",
                 i, misalignedFault, busFault, memReq, lsuDone);
      end
      step();
      n_vec++;
      if (misalignedFault !== 1'b0 || lsuBusy !== 1'b0 || memReq !== 1'b0) begin
        n_err++;
        $display("FAIL misaligned_end[%0d]: got mf=%b busy=%b req=%b, want 0 0 0", i, misalignedFault, lsuBusy, memReq);
      end
    end
  endtask
`endif

  task automatic test_gnt_stall();
    logic st; logic [31:0] oa, ow, orr; logic [3:0] ob; logic owe, od;
    run_op(1'b0, 3'b001, 32'h206, 32'h00005A5A, 32'h0, 3, st, oa, ob, ow, owe, od, orr);
    n_vec++;
    if (st !== 1'b1 || oa !== 32'h204 || ob !== 4'b1100 || ow !== 32'h5A5A5A5A || od !== 1'b1) begin
      n_err++;
      $display("FAIL gnt_stall: got stable=%b addr=%h be=%b wd=%h done=%b, want 1 00000204 1100 5a5a5a5a 1",
               st, oa, ob, ow, od);
    end
  endtask

  task automatic test_timeout();
    int unsigned reqc = 0, fcyc = 0;
    logic sawdone = 1'b0;
    lsuValid = 1'b1; lsuLoad = 1'b1; func3 = 3'b010; address = 32'h200;
    step();
    lsuValid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (fcyc == 0) begin
        if (memReq) reqc++;
        if (lsuDone) sawdone = 1'b1;
        if (busFault) fcyc = c;
        step();
      end
    end
    n_vec++;
    if (fcyc != 9 || reqc != 8 || sawdone !== 1'b0) begin
      n_err++;
      $display("FAIL timeout: got fault_cycle=%0d req_cycles=%0d done=%b, want 9 8 0", fcyc, reqc, sawdone);
    end
    n_vec++;
    if (lsuBusy !== 1'b0 || busFault !== 1'b0 || memReq !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_idle: got busy=%b bf=%b req=%b, want 0 0 0", lsuBusy, busFault, memReq);
    end
  endtask

  task automatic test_illegal();
    logic       lds[4];
    logic [2:0] f3s[4];
    lds[0] = 1'b1; f3s[0] = 3'b011;
    lds[1] = 1'b1; f3s[1] = 3'b111;
    lds[2] = 1'b0; f3s[2] = 3'b100;
    lds[3] = 1'b0; f3s[3] = 3'b011;
    for (int i = 0; i < 4; i++) begin
      lsuValid = 1'b1; lsuLoad = lds[i]; func3 = f3s[i]; address = 32'h100;
      step();
      lsuValid = 1'b0;
      n_vec++;
      if (busFault !== 1'b1 || misalignedFault !== 1'b0 || memReq !== 1'b0 || lsuDone !== 1'b0) begin
        n_err++;
        $display("FAIL illegal[%0d]: got bf=%b mf=%b req=%b done=%b, want 1 0 0 0",
                 i, busFault, misalignedFault, memReq, lsuDone);
      end
      step();
    end
  endtask

  task automatic test_reset_midop();
    logic st; logic [31:0] oa, ow, orr; logic [3:0] ob; logic owe, od;
    logic late_done = 1'b0;
    lsuValid = 1'b1; lsuLoad = 1'b1; func3 = 3'b010; address = 32'h300;
    step();
    lsuValid = 1'b0; memGnt = 1'b1;
    step();
    memGnt = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    n_vec++;
    if ({lsuBusy, lsuDone, misalignedFault, busFault, memReq, memWe} !== 6'b0 ||
        memAddr !== 32'h0 || memByteEn !== 4'h0 || loadResult !== 32'h0) begin
      n_err++;
      $display("FAIL reset_midop: got busy=%b done=%b req=%b addr=%h be=%b res=%h, want all 0",
               lsuBusy, lsuDone, memReq, memAddr, memByteEn, loadResult);
    end
    step();
    memRValid = 1'b1; memRData = 32'hCAFEF00D;
    step();
    memRValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (lsuDone || lsuBusy) late_done = 1'b1;
      step();
    end
    n_vec++;
    if (late_done !== 1'b0 || loadResult !== 32'h0) begin
      n_err++;
      $display("FAIL late_rvalid: got activity=%b res=%h, want 0 00000000", late_done, loadResult);
    end
    run_op(1'b1, 3'b010, 32'h304, 32'h0, 32'h87654321, 0, st, oa, ob, ow, owe, od, orr);
    n_vec++;
    if (od !== 1'b1 || orr !== 32'h87654321 || oa !== 32'h304 || st !== 1'b1) begin
      n_err++;
      $display("FAIL after_reset_op: got done=%b res=%h addr=%h reqok=%b, want 1 87654321 00000304 1", od, orr, oa, st);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned reqc = 0;
    logic d;
    lsuValid = 1'b1; lsuLoad = 1'b1; func3 = 3'b000; address = 32'h403;
    step();
    reqc += memReq; memGnt = 1'b1;
    step();
    memGnt = 1'b0; reqc += memReq;
    memRValid = 1'b1; memRData = 32'h7F000000;
    step();
    memRValid = 1'b0; lsuValid = 1'b0;
    d = lsuDone; reqc += memReq;
    step();
    n_vec++;
    if (reqc != 1 || d !== 1'b1 || loadResult !== 32'h0000007F || lsuBusy !== 1'b0) begin
      n_err++;
      $display("FAIL held_valid: got req_cycles=%0d done=%b res=%h busy=%b, want 1 1 0000007f 0",
               reqc, d, loadResult, lsuBusy);
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_misaligned();
    test_gnt_stall();
    test_timeout();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
